button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_conditioner_if.sv | 33 +++
 rtl/sync_2ff.sv | 38 +++
 rtl/button_conditioner.sv | 144 ++++++++++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg : shared state encodings and default timing for button logic
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package button_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000;

  // $clog2 collapses to 0 for tiny limits; keep at least one counter bit
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if : raw key input and conditioned button outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface button_conditioner_if;

  logic key_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic hold_pulse;

  modport master (
    output key_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  hold_pulse
  );

  modport slave (
    input  key_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output hold_pulse
  );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with synchronous active-low reset
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner : debounced push-button with press/release/hold strobes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_conditioner_if.slave   btn
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic key_s;
  logic pressed_s;

  logic [1:0]        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_done_q, hold_done_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              hold_q, hold_d;
  logic              level_q, level_d;

  // The unpressed raw level equals ACTIVE_LOW, so reset parks the synchronizer there
  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn.key_raw),
    .q     (key_s)
  );

  assign pressed_s = ACTIVE_LOW ? ~key_s : key_s;

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    hold_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d  = ST_PRESS_DB;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!pressed_s) begin
          state_d     = ST_IDLE;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_PRESSED;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
          press_d     = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d  = ST_RELEASE_DB;
          db_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Counter sits at its last value; the done flag limits the strobe to once per press
          if (!hold_done_q) begin
            hold_d      = 1'b1;
            hold_done_d = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        if (pressed_s) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = ST_IDLE;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          hold_done_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        db_cnt_d    = '0;
        hold_cnt_d  = '0;
        hold_done_d = 1'b0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_DB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      hold_q      <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      press_q     <= press_d;
      release_q   <= release_d;
      hold_q      <= hold_d;
      level_q     <= level_d;
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.hold_pulse    = hold_q;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner : scoreboard bench, active-low and active-high instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_button_conditioner;

  localparam int DB = 4;
  localparam int HC = 10;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_HOLD  = 3'b001;

  typedef struct packed {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic prs   = 1'b0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q_lo[$];
  exp_t q_hi[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner_if lo_if ();
  button_conditioner_if hi_if ();

  // Same physical press seen through both polarities
  assign lo_if.key_raw = ~prs;
  assign hi_if.key_raw = prs;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HC),
    .ACTIVE_LOW      (1'b1)
  ) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (lo_if)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HC),
    .ACTIVE_LOW      (1'b0)
  ) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (hi_if)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_evt(input logic [2:0] k, input int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    q_lo.push_back(e);
    q_hi.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_level(input string name, input logic exp);
    check({name, "_lo"}, int'(lo_if.btn_level), int'(exp));
    check({name, "_hi"}, int'(hi_if.btn_level), int'(exp));
  endtask

  always @(negedge clk) begin : mon_lo
    logic [2:0] p;
    exp_t       e;
    p = {lo_if.press_pulse, lo_if.release_pulse, lo_if.hold_pulse};
    if (mon_en && p != 3'b000) begin
      if (q_lo.size() == 0) begin
        check("lo_unexpected_pulse", int'(p), 0);
      end else begin
        e = q_lo.pop_front();
        check("lo_pulse_kind", int'(p), int'(e.kind));
        check("lo_pulse_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_hi
    logic [2:0] p;
    exp_t       e;
    p = {hi_if.press_pulse, hi_if.release_pulse, hi_if.hold_pulse};
    if (mon_en && p != 3'b000) begin
      if (q_hi.size() == 0) begin
        check("hi_unexpected_pulse", int'(p), 0);
      end else begin
        e = q_hi.pop_front();
        check("hi_pulse_kind", int'(p), int'(e.kind));
        check("hi_pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c0;
    prs   = 1'b0;
    rst_n = 1'b0;
    wait_cyc(3);
    check_level("rst_level", 1'b0);
    check("rst_press_lo", int'(lo_if.press_pulse), 0);
    check("rst_release_lo", int'(lo_if.release_pulse), 0);
    check("rst_hold_lo", int'(lo_if.hold_pulse), 0);
    check("rst_press_hi", int'(hi_if.press_pulse), 0);
    check("rst_release_hi", int'(hi_if.release_pulse), 0);
    check("rst_hold_hi", int'(hi_if.hold_pulse), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_cyc(3);

    // Clean press, held 20 cycles: press at +7, hold at +17
    c0 = cyc;
    prs = 1'b1;
    expect_evt(K_PRESS, c0 + 7);
    expect_evt(K_HOLD, c0 + 17);
    wait_cyc(6);
    check_level("press_level_before", 1'b0);
    wait_cyc(1);
    check_level("press_level_after", 1'b1);
    wait_cyc(13);

    // Clean release: release at +7
    c0 = cyc;
    prs = 1'b0;
    expect_evt(K_REL, c0 + 7);
    wait_cyc(6);
    check_level("release_level_before", 1'b1);
    wait_cyc(1);
    check_level("release_level_after", 1'b0);
    wait_cyc(5);

    // Bounce: 2-cycle pressed/unpressed runs never reach the debounce count
    for (int i = 0; i < 12; i++) begin
      prs = ((i / 2) % 2) == 0;
      wait_cyc(1);
      check_level("bounce_level", 1'b0);
    end
    prs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(1);
      check_level("bounce_tail_level", 1'b0);
    end

    // Release glitch while pressed: hold counter pauses for 3 cycles, hold at +20
    c0 = cyc;
    prs = 1'b1;
    expect_evt(K_PRESS, c0 + 7);
    wait_cyc(8);
    prs = 1'b0;
    wait_cyc(2);
    prs = 1'b1;
    expect_evt(K_HOLD, c0 + 20);
    wait_cyc(2);
    check_level("glitch_level", 1'b1);
    wait_cyc(12);
    prs = 1'b0;
    expect_evt(K_REL, c0 + 31);
    wait_cyc(12);
    check_level("glitch_end_level", 1'b0);

    // Reset mid-press: no release, re-debounced press 7 edges after reset release
    c0 = cyc;
    prs = 1'b1;
    expect_evt(K_PRESS, c0 + 7);
    wait_cyc(10);
    check_level("pre_reset_level", 1'b1);
    rst_n = 1'b0;
    wait_cyc(1);
    check_level("in_reset_level", 1'b0);
    rst_n = 1'b1;
    expect_evt(K_PRESS, c0 + 18);
    expect_evt(K_HOLD, c0 + 28);
    wait_cyc(6);
    check_level("post_reset_level_before", 1'b0);
    wait_cyc(1);
    check_level("post_reset_level_after", 1'b1);
    wait_cyc(13);
    prs = 1'b0;
    expect_evt(K_REL, c0 + 38);
    wait_cyc(12);
    check_level("final_level", 1'b0);

    check("lo_missing_events", q_lo.size(), 0);
    check("hi_missing_events", q_hi.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
